bit_op_unit: RTL and testbench

Parametrised, sequential successor to the 16-bit single-bit write operator. It adds set, clear, toggle and test operations, plus multi-cycle range operations over bits BS..BE. Requests and results use valid/ready handshakes, so the unit can sit in the datapath between the register file and the ALU result mux, and it flags illegal index requests.

---
 rtl/bit_op_unit.sv | 139 +++++++++++++
 tb/tb_bit_op_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_op_unit.sv
// Sequential bit-manipulation unit: single-bit write/set/clear/toggle/test and
// multi-cycle range write/toggle, with valid/ready handshakes on both sides.
module bit_op_unit #(
  parameter int WIDTH = 16,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [IDXW-1:0]  bs,
  input  logic [IDXW-1:0]  be,
  input  logic             s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             z,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_WRITE  = 3'b000;
  localparam logic [2:0] OP_SET    = 3'b001;
  localparam logic [2:0] OP_CLR    = 3'b010;
  localparam logic [2:0] OP_TGL    = 3'b011;
  localparam logic [2:0] OP_TEST   = 3'b100;
  localparam logic [2:0] OP_WRITER = 3'b101;
  localparam logic [2:0] OP_TGLR   = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  localparam logic [IDXW:0] WIDTH_L = (IDXW+1)'(WIDTH);

  state_t           state_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] work_next;
  logic [IDXW-1:0]  cnt_reg;
  logic [IDXW-1:0]  be_reg;
  logic             s_reg;
  logic             tgl_reg;

  logic             is_range;
  logic             illegal;
  logic [WIDTH-1:0] single_f;
  logic             single_z;
  logic             run_bit;

  assign is_range = (op == OP_WRITER) || (op == OP_TGLR);
  assign illegal  = (op == OP_RSVD) || ({1'b0, bs} >= WIDTH_L) ||
                    (is_range && (({1'b0, be} >= WIDTH_L) || (be < bs)));

  // Illegal requests fall through here too: F=A, ERR=1, Z from F.
  always_comb begin
    single_f = a;
    single_z = 1'b0;
    if (!illegal) begin
      case (op)
        OP_WRITE: single_f[bs] = s;
        OP_SET:   single_f[bs] = 1'b1;
        OP_CLR:   single_f[bs] = 1'b0;
        OP_TGL:   single_f[bs] = ~a[bs];
        default:  ;
      endcase
    end
    single_z = (single_f == '0);
    if (!illegal && (op == OP_TEST)) single_z = ~a[bs];
  end

  assign run_bit = tgl_reg ? ~work_reg[cnt_reg] : s_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_work
      assign work_next[gi] = (cnt_reg == IDXW'(gi)) ? run_bit : work_reg[gi];
    end
  endgenerate

  // Terminate test happens before increment, so BE=WIDTH-1 never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      f         <= '0;
      z         <= 1'b0;
      err       <= 1'b0;
      work_reg  <= '0;
      cnt_reg   <= '0;
      be_reg    <= '0;
      s_reg     <= 1'b0;
      tgl_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (is_range && !illegal) begin
              work_reg  <= a;
              cnt_reg   <= bs;
              be_reg    <= be;
              s_reg     <= s;
              tgl_reg   <= (op == OP_TGLR);
              state_reg <= RUN;
            end else begin
              f         <= single_f;
              z         <= single_z;
              err       <= illegal;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        RUN: begin
          work_reg <= work_next;
          if (cnt_reg == be_reg) begin
            f         <= work_next;
            z         <= (work_next == '0);
            err       <= 1'b0;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_op_unit.sv
// Directed self-checking bench for bit_op_unit: behavioural model plus
// hand-computed literal expectations per vector.
module tb_bit_op_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a;
  logic [3:0]  bs;
  logic [3:0]  be;
  logic        s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] f;
  logic        z;
  logic        err;

  bit_op_unit #(.WIDTH(16), .IDXW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .bs(bs), .be(be), .s(s),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .z(z), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    int          bs;
    int          be;
    bit          s;
    logic [15:0] ef;
    bit          ez;
    bit          eerr;
    int          elat;
  } vec_t;

  vec_t vecs[14];

  int checks = 0;
  int passes = 0;

  logic [15:0] exp_f;
  bit          exp_z;
  bit          exp_err;
  bit          busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Model from the operation rules: latency counts the accept edge as edge 1.
  task automatic model(input vec_t v, output logic [15:0] ef, output bit ez,
                       output bit eerr, output int lat);
    bit range_op;
    bit bad;
    range_op = (v.op == 3'd5) || (v.op == 3'd6);
    bad = (v.op == 3'd7) || (v.bs >= 16) || (range_op && (v.be >= 16 || v.be < v.bs));
    ef = v.a;
    lat = 1;
    eerr = bad;
    if (!bad) begin
      case (v.op)
        3'd0: ef = (v.a & ~(16'd1 << v.bs)) | (16'(v.s) << v.bs);
        3'd1: ef = v.a | (16'd1 << v.bs);
        3'd2: ef = v.a & ~(16'd1 << v.bs);
        3'd3: ef = v.a ^ (16'd1 << v.bs);
        3'd5, 3'd6: begin
          for (int i = v.bs; i <= v.be; i++) ef[i] = (v.op == 3'd5) ? v.s : ~v.a[i];
          lat = v.be - v.bs + 2;
        end
        default: ;
      endcase
    end
    ez = (!bad && v.op == 3'd4) ? ~v.a[v.bs] : (ef == 16'h0000);
  endtask

  // Continuous compare against the model while the unit is busy or idle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        chk("f", 32'(f), 32'(exp_f));
        chk("z", 32'(z), 32'(exp_z));
        chk("err", 32'(err), 32'(exp_err));
      end
      if (busy) chk("in_ready_busy", 32'(in_ready), 32'd0);
      else      chk("out_valid_idle", 32'(out_valid), 32'd0);
    end
  end

  task automatic drive(input vec_t v);
    op = v.op; a = v.a; bs = 4'(v.bs); be = 4'(v.be); s = v.s;
    in_valid = 1'b1;
  endtask

  // Inputs already presented; wait for accept, then for the result.
  task automatic accept_and_wait(input vec_t v, output int waited);
    int lat;
    int elat;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) chk("accept_timeout", 32'(waited), 32'd0);
    model(v, exp_f, exp_z, exp_err, elat);
    @(posedge clk);
    busy = 1'b1;
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~a; op = 3'd1; bs = ~bs; s = ~s;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("lit_f", 32'(f), 32'(v.ef));
    chk("lit_z", 32'(z), 32'(v.ez));
    chk("lit_err", 32'(err), 32'(v.eerr));
    chk("lit_latency", 32'(lat), 32'(v.elat));
  endtask

  task automatic drain(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      chk("out_valid_hold", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    busy = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_ready", 32'(in_ready), 32'd1);
    chk("f_retained", 32'(f), 32'(exp_f));
  endtask

  initial begin
    int w;
    vecs[0]  = '{3'd0, 16'h0000, 15, 0, 1'b1, 16'h8000, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'd1, 16'hFFFE, 0, 0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'd2, 16'h0008, 3, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 1};
    vecs[3]  = '{3'd4, 16'h0010, 4, 0, 1'b0, 16'h0010, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'd4, 16'h0010, 5, 0, 1'b0, 16'h0010, 1'b1, 1'b0, 1};
    vecs[5]  = '{3'd6, 16'h00FF, 4, 11, 1'b0, 16'h0F0F, 1'b0, 1'b0, 9};
    vecs[6]  = '{3'd5, 16'h0000, 0, 15, 1'b1, 16'hFFFF, 1'b0, 1'b0, 17};
    vecs[7]  = '{3'd5, 16'h1234, 8, 3, 1'b1, 16'h1234, 1'b0, 1'b1, 1};
    vecs[8]  = '{3'd7, 16'h0000, 2, 9, 1'b1, 16'h0000, 1'b1, 1'b1, 1};
    vecs[9]  = '{3'd3, 16'h5555, 0, 0, 1'b0, 16'h5554, 1'b0, 1'b0, 1};
    vecs[10] = '{3'd0, 16'hFFFF, 7, 0, 1'b0, 16'hFF7F, 1'b0, 1'b0, 1};
    vecs[11] = '{3'd6, 16'h0000, 7, 7, 1'b0, 16'h0080, 1'b0, 1'b0, 2};
    vecs[12] = '{3'd5, 16'hFFFF, 2, 5, 1'b0, 16'hFFC3, 1'b0, 1'b0, 5};
    vecs[13] = '{3'd0, 16'h8000, 15, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 1};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; bs = '0; be = '0; s = 1'b0;
    out_ready = 1'b0;
    exp_f = '0; exp_z = 1'b0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      accept_and_wait(vecs[i], w);
      $display("vec %0d op=%0d a=%h bs=%0d be=%0d s=%0d -> f=%h z=%0d err=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].bs, vecs[i].be, vecs[i].s, f, z, err);
      drain(i % 3);
    end

    // Backpressure: result parked in DONE while the next request is held.
    @(negedge clk);
    drive(vecs[0]);
    accept_and_wait(vecs[0], w);
    drive(vecs[9]);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    busy = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_drained", 32'(out_valid), 32'd0);
    accept_and_wait(vecs[9], w);
    chk("bp_accept_next_edge", 32'(w), 32'd0);
    $display("backpressure held request -> f=%h z=%0d err=%0d", f, z, err);
    drain(0);

    // Reset asserted mid-RUN of a range toggle.
    @(negedge clk);
    drive(vecs[5]);
    @(posedge clk);
    busy = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    busy = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_f", 32'(f), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    $display("reset mid-run -> f=%h out_valid=%0d in_ready=%0d", f, out_valid, in_ready);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", passes);
    $fatal(1);
  end

endmodule
